// File: rtl/axi_sram_bridge_if.sv
// rtl/axi_sram_bridge_if.sv - AXI4 memory-port bundle between the core master and the SRAM bridge
interface axi_sram_bridge_if #(
  parameter int ID_WIDTH = 4
);
  // write address channel
  logic                aw_ready;
  logic                aw_valid;
  logic [ID_WIDTH-1:0] aw_id;
  logic [31:0]         aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  // write data channel
  logic                w_ready;
  logic                w_valid;
  logic [63:0]         w_data;
  logic [7:0]          w_strb;
  logic                w_last;
  // write response channel
  logic                b_ready;
  logic                b_valid;
  logic [ID_WIDTH-1:0] b_id;
  logic [1:0]          b_resp;
  // read address channel
  logic                ar_ready;
  logic                ar_valid;
  logic [ID_WIDTH-1:0] ar_id;
  logic [31:0]         ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  // read data channel
  logic                r_ready;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;
  logic [63:0]         r_data;
  logic [1:0]          r_resp;
  logic                r_last;

  modport master (
    input  aw_ready, output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  w_ready,  output w_valid, w_data, w_strb, w_last,
    output b_ready,  input  b_valid, b_id, b_resp,
    input  ar_ready, output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output r_ready,  input  r_valid, r_id, r_data, r_resp, r_last
  );

  modport slave (
    output aw_ready, input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output w_ready,  input  w_valid, w_data, w_strb, w_last,
    input  b_ready,  output b_valid, b_id, b_resp,
    output ar_ready, input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  r_ready,  output r_valid, r_id, r_data, r_resp, r_last
  );
endinterface

// File: rtl/axi_sram_bridge.sv
// rtl/axi_sram_bridge.sv - AXI4 slave serving one burst at a time from a single-port 64-bit SRAM
module axi_sram_bridge #(
  parameter int ID_WIDTH = 4,
  parameter int MEM_AW   = 16
) (
  input  logic              clock,
  input  logic              reset,
  axi_sram_bridge_if.slave  io_axi4_0,
  output logic              mem_en,
  output logic [7:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_WRESP = 3'd2,
    S_RREQ  = 3'd3,
    S_RWAIT = 3'd4,
    S_RRESP = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_pri_rd;   // 1: read wins the next simultaneous request
  logic [ID_WIDTH-1:0] r_id;
  logic [MEM_AW+2:0]   r_addr;     // byte address, only the bits that reach the SRAM
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;
  logic [1:0]          r_size;     // effective size, oversize requests clamp to 8 bytes
  logic                r_fixed;
  logic                r_err;
  logic                r_w_ready;
  logic                r_b_valid;
  logic                r_r_valid;
  logic                r_r_last;
  logic                r_rd_en;
  logic [63:0]         r_rdata;

  logic                w_idle;
  logic                w_aw_hs;
  logic                w_ar_hs;
  logic                w_w_hs;
  logic                w_last_beat;
  logic [MEM_AW+2:0]   w_step;
  logic [MEM_AW+2:0]   w_addr_next;
  logic [ID_WIDTH-1:0] w_req_id;
  logic [31:0]         w_req_addr;
  logic [7:0]          w_req_len;
  logic [2:0]          w_req_size;
  logic [1:0]          w_req_burst;
  logic                w_req_err;
  logic                w_unused_addr;

  // Address-channel arbitration; readies are held low while reset is asserted.
  assign w_idle  = (r_state == S_IDLE) && reset;
  assign w_aw_hs = w_idle && io_axi4_0.aw_valid && (!io_axi4_0.ar_valid || !r_pri_rd);
  assign w_ar_hs = w_idle && io_axi4_0.ar_valid && (!io_axi4_0.aw_valid || r_pri_rd);
  assign w_w_hs  = r_w_ready && io_axi4_0.w_valid;

  // Request fields of whichever channel is granted this cycle.
  assign w_req_id    = w_aw_hs ? io_axi4_0.aw_id    : io_axi4_0.ar_id;
  assign w_req_addr  = w_aw_hs ? io_axi4_0.aw_addr  : io_axi4_0.ar_addr;
  assign w_req_len   = w_aw_hs ? io_axi4_0.aw_len   : io_axi4_0.ar_len;
  assign w_req_size  = w_aw_hs ? io_axi4_0.aw_size  : io_axi4_0.ar_size;
  assign w_req_burst = w_aw_hs ? io_axi4_0.aw_burst : io_axi4_0.ar_burst;
  // WRAP and reserved bursts share burst[1]; sizes above 8 bytes share size[2].
  assign w_req_err   = w_req_burst[1] || w_req_size[2];
  // Address bits above the SRAM window alias and are deliberately dropped.
  assign w_unused_addr = ^w_req_addr[31:MEM_AW+3];

  // Beat address stepping; truncation to the register width gives the modulo wrap.
  assign w_last_beat = (r_cnt == r_len);
  assign w_step      = {{(MEM_AW+2){1'b0}}, 1'b1} << r_size;
  assign w_addr_next = r_fixed ? r_addr : (r_addr + w_step);

  // SRAM port: writes pass straight through on a w handshake, reads come from RREQ.
  assign mem_en    = w_w_hs || r_rd_en;
  assign mem_we    = w_w_hs ? io_axi4_0.w_strb : 8'h00;
  assign mem_wdata = w_w_hs ? io_axi4_0.w_data : 64'h0;
  assign mem_addr  = r_addr[MEM_AW+2:3];

  // Response channels are driven from registered state only.
  assign io_axi4_0.aw_ready = w_aw_hs;
  assign io_axi4_0.ar_ready = w_ar_hs;
  assign io_axi4_0.w_ready  = r_w_ready;
  assign io_axi4_0.b_valid  = r_b_valid;
  assign io_axi4_0.b_id     = r_id;
  assign io_axi4_0.b_resp   = {r_b_valid && r_err, 1'b0};
  assign io_axi4_0.r_valid  = r_r_valid;
  assign io_axi4_0.r_id     = r_id;
  assign io_axi4_0.r_data   = r_rdata;
  assign io_axi4_0.r_resp   = {r_r_valid && r_err, 1'b0};
  assign io_axi4_0.r_last   = r_r_last;

  // Transaction FSM: latches a request, walks its beats, returns one response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pri_rd  <= 1'b1;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= 8'h00;
      r_cnt     <= 8'h00;
      r_size    <= 2'd0;
      r_fixed   <= 1'b0;
      r_err     <= 1'b0;
      r_w_ready <= 1'b0;
      r_b_valid <= 1'b0;
      r_r_valid <= 1'b0;
      r_r_last  <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rdata   <= 64'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_hs || w_ar_hs) begin
            r_id    <= w_req_id;
            r_addr  <= w_req_addr[MEM_AW+2:0];
            r_len   <= w_req_len;
            r_cnt   <= 8'h00;
            r_size  <= w_req_size[2] ? 2'd3 : w_req_size[1:0];
            r_fixed <= (w_req_burst == 2'b00);
            r_err   <= w_req_err;
          end
          if (w_aw_hs) begin
            r_w_ready <= 1'b1;
            r_pri_rd  <= 1'b1;
            r_state   <= S_WDATA;
          end else if (w_ar_hs) begin
            r_rd_en   <= 1'b1;
            r_pri_rd  <= 1'b0;
            r_state   <= S_RREQ;
          end
        end
        S_WDATA: begin
          if (w_w_hs) begin
            r_addr <= w_addr_next;
            r_cnt  <= r_cnt + 8'd1;
            if (io_axi4_0.w_last != w_last_beat) begin
              r_err <= 1'b1;
            end
            // The beat count alone ends the burst; a misplaced w_last only flags it.
            if (w_last_beat) begin
              r_w_ready <= 1'b0;
              r_b_valid <= 1'b1;
              r_state   <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (io_axi4_0.b_ready) begin
            r_b_valid <= 1'b0;
            r_err     <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_RREQ: begin
          r_rd_en <= 1'b0;
          r_state <= S_RWAIT;
        end
        S_RWAIT: begin
          r_rdata   <= mem_rdata;
          r_r_valid <= 1'b1;
          r_r_last  <= w_last_beat;
          r_state   <= S_RRESP;
        end
        S_RRESP: begin
          if (io_axi4_0.r_ready) begin
            r_r_valid <= 1'b0;
            r_r_last  <= 1'b0;
            if (w_last_beat) begin
              r_err   <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_addr  <= w_addr_next;
              r_cnt   <= r_cnt + 8'd1;
              r_rd_en <= 1'b1;
              r_state <= S_RREQ;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// tb/tb_axi_sram_bridge.sv - randomized bench for axi_sram_bridge against a transaction-level memory model
module tb_axi_sram_bridge;

  logic        clock;
  logic        reset;
  logic        mem_en;
  logic [7:0]  mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  axi_sram_bridge_if #(.ID_WIDTH(4)) bus ();

  axi_sram_bridge #(.ID_WIDTH(4), .MEM_AW(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .io_axi4_0 (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Physical SRAM seen by the DUT.
  logic [63:0] sram [0:65535];
  int          n_mem_en = 0;

  always @(posedge clock) begin
    if (mem_en) begin
      n_mem_en <= n_mem_en + 1;
      if (mem_we == 8'h00) begin
        mem_rdata <= sram[mem_addr];
      end else begin
        for (int b = 0; b < 8; b++) begin
          if (mem_we[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Reference memory, updated from the AXI-level view of each write beat.
  logic [63:0] ref_mem [0:65535];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Current transaction
  logic [3:0]  t_id;
  logic [31:0] t_addr;
  int          t_len;
  logic [2:0]  t_size;
  logic [1:0]  t_burst;
  logic [63:0] t_data [0:255];
  logic [7:0]  t_strb [0:255];
  logic        t_last [0:255];

  function automatic logic [15:0] word_of(input logic [31:0] a);
    return 16'((a / 8) % 65536);
  endfunction

  function automatic logic [31:0] step_addr(input logic [31:0] a);
    int eff;
    eff = (t_size > 3'd3) ? 3 : int'(t_size);
    if (t_burst == 2'b00) return a;
    return a + (32'd1 << eff);
  endfunction

  function automatic logic exp_err();
    return (t_burst >= 2'b10) || (t_size > 3'd3);
  endfunction

  task automatic prep(input logic [3:0] id, input logic [31:0] addr, input int len,
                      input logic [2:0] size, input logic [1:0] burst);
    t_id = id; t_addr = addr; t_len = len; t_size = size; t_burst = burst;
    for (int i = 0; i < 256; i++) begin
      t_data[i] = {$urandom, $urandom};
      t_strb[i] = 8'hFF;
      t_last[i] = (i == len);
    end
  endtask

  task automatic drive_aw();
    bus.aw_id = t_id; bus.aw_addr = t_addr; bus.aw_len = 8'(t_len);
    bus.aw_size = t_size; bus.aw_burst = t_burst;
  endtask

  task automatic drive_ar();
    bus.ar_id = t_id; bus.ar_addr = t_addr; bus.ar_len = 8'(t_len);
    bus.ar_size = t_size; bus.ar_burst = t_burst;
  endtask

  task automatic aw_phase();
    int n;
    drive_aw();
    bus.aw_valid = 1'b1;
    n = 0;
    #1;
    while (!bus.aw_ready && n < 50) begin @(negedge clock); #1; n++; end
    chk("aw_grant", bus.aw_ready, 1);
    @(negedge clock);
    bus.aw_valid = 1'b0;
  endtask

  task automatic ar_phase();
    int n;
    drive_ar();
    bus.ar_valid = 1'b1;
    n = 0;
    #1;
    while (!bus.ar_ready && n < 50) begin @(negedge clock); #1; n++; end
    chk("ar_grant", bus.ar_ready, 1);
    @(negedge clock);
    bus.ar_valid = 1'b0;
  endtask

  // Drives the w beats; abort_after >= 0 stops before that beat with w_valid left high.
  task automatic w_phase(input int abort_after, input int base);
    logic [31:0] a;
    logic        err;
    int          n;
    logic [15:0] w;
    a = t_addr;
    err = exp_err();
    for (int i = 0; i <= t_len; i++) begin
      if (abort_after >= 0 && i == abort_after) return;
      bus.w_valid = 1'b1; bus.w_data = t_data[i]; bus.w_strb = t_strb[i]; bus.w_last = t_last[i];
      n = 0;
      #1;
      while (!bus.w_ready && n < 20) begin @(negedge clock); #1; n++; end
      w = word_of(a);
      chk("w_ready", bus.w_ready, 1);
      chk("w_mem_en", mem_en, 1);
      chk("w_mem_addr", mem_addr, w);
      chk("w_mem_we", mem_we, t_strb[i]);
      chk("w_mem_wdata", mem_wdata, t_data[i]);
      for (int b = 0; b < 8; b++) if (t_strb[i][b]) ref_mem[w][b*8 +: 8] = t_data[i][b*8 +: 8];
      if (t_last[i] != (i == t_len)) err = 1'b1;
      a = step_addr(a);
      @(negedge clock);
    end
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    #1;
    chk("b_valid_lat", bus.b_valid, 1);
    chk("b_id", bus.b_id, t_id);
    chk("b_resp", bus.b_resp, err ? 2'b10 : 2'b00);
    chk("wresp_no_mem", mem_en, 0);
    chk("w_mem_count", n_mem_en - base, t_len + 1);
    bus.b_ready = 1'b1;
    @(negedge clock);
    bus.b_ready = 1'b0;
    #1;
    chk("b_valid_drop", bus.b_valid, 0);
  endtask

  task automatic r_phase(input int stall_min, input int stall_max);
    logic [31:0] a;
    logic        err;
    logic [63:0] exp;
    int          n;
    int          base;
    int          stall;
    a = t_addr;
    err = exp_err();
    base = n_mem_en;
    n = 1;
    for (int i = 0; i <= t_len; i++) begin
      while (!bus.r_valid && n < 20) begin @(negedge clock); n++; end
      exp = ref_mem[word_of(a)];
      chk("r_lat", n, 3);
      chk("r_data", bus.r_data, exp);
      chk("r_id", bus.r_id, t_id);
      chk("r_last", bus.r_last, i == t_len);
      chk("r_resp", bus.r_resp, err ? 2'b10 : 2'b00);
      stall = $urandom_range(stall_min, stall_max);
      for (int s = 0; s < stall; s++) begin
        @(negedge clock);
        chk("stall_valid", bus.r_valid, 1);
        chk("stall_data", bus.r_data, exp);
        chk("stall_last", bus.r_last, i == t_len);
        chk("stall_resp", bus.r_resp, err ? 2'b10 : 2'b00);
      end
      bus.r_ready = 1'b1;
      @(negedge clock);
      bus.r_ready = 1'b0;
      a = step_addr(a);
      n = 1;
    end
    chk("r_valid_drop", bus.r_valid, 0);
    chk("r_mem_count", n_mem_en - base, t_len + 1);
  endtask

  task automatic do_write(input int abort_after);
    int base;
    base = n_mem_en;
    aw_phase();
    w_phase(abort_after, base);
  endtask

  task automatic do_read(input int smin, input int smax);
    ar_phase();
    r_phase(smin, smax);
  endtask

  initial begin
    reset = 1'b0;
    bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
    bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0; bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0;
    bus.r_ready = 0;
    for (int i = 0; i < 65536; i++) begin sram[i] = 64'h0; ref_mem[i] = 64'h0; end

    // Reset state
    repeat (3) @(negedge clock);
    bus.aw_valid = 1'b1; bus.ar_valid = 1'b1;
    #1;
    chk("rst_aw_ready", bus.aw_ready, 0);
    chk("rst_ar_ready", bus.ar_ready, 0);
    chk("rst_w_ready", bus.w_ready, 0);
    chk("rst_b_valid", bus.b_valid, 0);
    chk("rst_r_valid", bus.r_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Single write then read back
    prep(4'd3, 32'h8000_0010, 0, 3'd3, 2'b01);
    t_data[0] = 64'h1122_3344_5566_7788;
    do_write(-1);
    chk("single_ref", ref_mem[2], 64'h1122_3344_5566_7788);
    prep(4'd5, 32'h8000_0010, 0, 3'd3, 2'b01);
    do_read(0, 0);

    // 4-beat INCR write with a partial strobe on beat 2, then a stalled read
    prep(4'd1, 32'h0, 3, 3'd3, 2'b01);
    t_strb[2] = 8'h0F;
    do_write(-1);
    prep(4'd2, 32'h0, 3, 3'd3, 2'b01);
    do_read(5, 5);

    // Simultaneous requests after a write: read first, then write
    prep(4'd9, 32'h0, 0, 3'd3, 2'b01);
    do_write(-1);
    prep(4'd8, 32'h48, 0, 3'd3, 2'b01);
    drive_aw();
    prep(4'd7, 32'h40, 0, 3'd3, 2'b01);
    drive_ar();
    bus.aw_valid = 1'b1; bus.ar_valid = 1'b1;
    #1;
    chk("arb1_ar_ready", bus.ar_ready, 1);
    chk("arb1_aw_ready", bus.aw_ready, 0);
    @(negedge clock);
    bus.ar_valid = 1'b0;
    #1;
    chk("arb_busy_aw", bus.aw_ready, 0);
    r_phase(0, 0);
    prep(4'd8, 32'h48, 0, 3'd3, 2'b01);
    bus.ar_valid = 1'b1;
    #1;
    chk("arb2_aw_ready", bus.aw_ready, 1);
    chk("arb2_ar_ready", bus.ar_ready, 0);
    @(negedge clock);
    bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
    w_phase(-1, n_mem_en);

    // Misplaced w_last on a 2-beat write
    prep(4'd4, 32'h80, 1, 3'd3, 2'b01);
    t_last[0] = 1'b1; t_last[1] = 1'b0;
    do_write(-1);

    // WRAP read flags every beat
    prep(4'd6, 32'h0, 3, 3'd3, 2'b10);
    do_read(0, 1);

    // Word address wraps at the top of the SRAM
    prep(4'd10, 32'h0007_FFF8, 1, 3'd3, 2'b01);
    do_write(-1);
    prep(4'd11, 32'h0007_FFF8, 1, 3'd3, 2'b01);
    do_read(0, 0);

    // Oversize beats clamp to 8 bytes and flag an error
    prep(4'd12, 32'h100, 1, 3'd5, 2'b01);
    do_write(-1);

    // FIXED burst keeps hitting one word
    prep(4'd13, 32'h300, 2, 3'd3, 2'b00);
    do_write(-1);
    prep(4'd14, 32'h300, 0, 3'd3, 2'b01);
    do_read(0, 0);

    // Reset in the middle of a 4-beat write
    prep(4'd15, 32'h200, 3, 3'd3, 2'b01);
    aw_phase();
    w_phase(2, n_mem_en);
    bus.aw_valid = 1'b1; bus.ar_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("mid_rst_w_ready", bus.w_ready, 0);
    chk("mid_rst_aw_ready", bus.aw_ready, 0);
    chk("mid_rst_ar_ready", bus.ar_ready, 0);
    chk("mid_rst_b_valid", bus.b_valid, 0);
    chk("mid_rst_r_valid", bus.r_valid, 0);
    chk("mid_rst_r_last", bus.r_last, 0);
    chk("mid_rst_ids", {bus.b_id, bus.r_id, bus.b_resp, bus.r_resp}, 0);
    chk("mid_rst_r_data", bus.r_data, 0);
    chk("mid_rst_mem", {mem_en, mem_we, mem_addr}, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    @(negedge clock);
    bus.w_valid = 1'b0; bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("post_rst_b_valid", bus.b_valid, 0);
      chk("post_rst_mem_en", mem_en, 0);
    end
    prep(4'd2, 32'h208, 0, 3'd3, 2'b01);
    do_write(-1);
    prep(4'd3, 32'h200, 2, 3'd3, 2'b01);
    do_read(0, 0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra;
      logic [2:0]  rs;
      logic [1:0]  rb;
      ra = $urandom & 32'hFFF8_0FFF;
      rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      rb = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      prep(4'($urandom), ra, $urandom_range(0, 7), rs, rb);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= t_len; i++) t_strb[i] = 8'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          int j;
          j = $urandom_range(0, t_len);
          t_last[j] = ~t_last[j];
        end
        do_write(-1);
      end else begin
        do_read(0, 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
